// File: rtl/result_stream_tx.sv
// result_stream_tx: reads a frame of words from a synchronous BRAM and streams them LSB-byte-first
// into a byte UART using tx_busy handshaking. Define RESULT_STREAM_CSUM_EN to append a checksum.
module result_stream_tx #(
    parameter int unsigned FRAME_LEN = 3969,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned RD_LAT    = 2,
    parameter int unsigned ACK_TO    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              tx_enable,
    output logic [7:0]        tx_data,
    input  logic              tx_busy,
    output logic [ADDR_W:0]   words_sent
);
    localparam int unsigned NB     = DATA_W / 8;
    localparam int unsigned BIDX_W = (NB > 1) ? $clog2(NB) : 1;
    localparam int unsigned ACK_W  = (ACK_TO > 1) ? $clog2(ACK_TO) : 1;

    localparam logic [BIDX_W-1:0] LAST_BIDX = BIDX_W'(NB - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);
    localparam logic [1:0]        LAT_END   = 2'(RD_LAT - 1);
    localparam logic [ACK_W-1:0]  ACK_END   = ACK_W'(ACK_TO - 1);

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StLoad,
        StSend,
        StAck,
        StDrain,
`ifdef RESULT_STREAM_CSUM_EN
        StCsum,
`endif
        StFin
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          lat_q, lat_d;
    logic [ACK_W-1:0]    ack_q, ack_d;
    logic [BIDX_W-1:0]   bidx_q, bidx_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     words_q, words_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                txen_q, txen_d;
    logic [7:0]          txd_q, txd_d;
    logic                csum_byte;
`ifdef RESULT_STREAM_CSUM_EN
    logic [7:0]          csum_q, csum_d;
    logic                csum_flag_q, csum_flag_d;

    assign csum_byte = csum_flag_q;
`else
    assign csum_byte = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        ack_d   = ack_q;
        bidx_d  = bidx_q;
        shift_d = shift_q;
        addr_d  = addr_q;
        words_d = words_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        txen_d  = 1'b0;
        txd_d   = txd_q;
`ifdef RESULT_STREAM_CSUM_EN
        csum_d      = csum_q;
        csum_flag_d = csum_flag_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    addr_d  = '0;
                    words_d = '0;
                    lat_d   = '0;
                    busy_d  = 1'b1;
                    state_d = StRead;
`ifdef RESULT_STREAM_CSUM_EN
                    csum_d      = '0;
                    csum_flag_d = 1'b0;
`endif
                end
            end
            StRead: begin
                if (lat_q == LAT_END) state_d = StLoad;
                else                  lat_d   = lat_q + 1'b1;
            end
            StLoad: begin
                shift_d = rd_data;
                bidx_d  = '0;
                state_d = StSend;
            end
            StSend: begin
                if (!tx_busy) begin
                    txd_d   = shift_q[7:0];
                    txen_d  = 1'b1;
                    ack_d   = '0;
                    state_d = StAck;
`ifdef RESULT_STREAM_CSUM_EN
                    if (!csum_flag_q) csum_d = csum_q + shift_q[7:0];
`endif
                end
            end
            StAck: begin
                // A UART that never raises busy still lets the byte through after the timeout.
                if (tx_busy || ack_q == ACK_END) state_d = StDrain;
                else                             ack_d   = ack_q + 1'b1;
            end
            StDrain: begin
                if (!tx_busy) begin
                    if (csum_byte) begin
                        state_d = StFin;
                        done_d  = 1'b1;
                    end else if (bidx_q != LAST_BIDX) begin
                        shift_d = shift_q >> 8;
                        bidx_d  = bidx_q + 1'b1;
                        state_d = StSend;
                    end else begin
                        words_d = words_q + 1'b1;
                        if (addr_q != LAST_ADDR) begin
                            addr_d  = addr_q + 1'b1;
                            lat_d   = '0;
                            state_d = StRead;
                        end else begin
`ifdef RESULT_STREAM_CSUM_EN
                            state_d = StCsum;
`else
                            state_d = StFin;
                            done_d  = 1'b1;
`endif
                        end
                    end
                end
            end
`ifdef RESULT_STREAM_CSUM_EN
            StCsum: begin
                shift_d     = DATA_W'(csum_q);
                csum_flag_d = 1'b1;
                state_d     = StSend;
            end
`endif
            StFin: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            lat_q   <= '0;
            ack_q   <= '0;
            bidx_q  <= '0;
            shift_q <= '0;
            addr_q  <= '0;
            words_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            txen_q  <= 1'b0;
            txd_q   <= '0;
`ifdef RESULT_STREAM_CSUM_EN
            csum_q      <= '0;
            csum_flag_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            ack_q   <= ack_d;
            bidx_q  <= bidx_d;
            shift_q <= shift_d;
            addr_q  <= addr_d;
            words_q <= words_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            txen_q  <= txen_d;
            txd_q   <= txd_d;
`ifdef RESULT_STREAM_CSUM_EN
            csum_q      <= csum_d;
            csum_flag_q <= csum_flag_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign rd_addr    = addr_q;
    assign tx_enable  = txen_q;
    assign tx_data    = txd_q;
    assign words_sent = words_q;
endmodule

// File: doc/result_stream_tx.md
# result_stream_tx

Parametrised frame streamer that sits between a result BRAM, read through a synchronous port with configurable latency, and the byte-wide `uart_tx`. On a `start` pulse it reads `FRAME_LEN` words from address 0 upward. It serialises each `DATA_W`-bit word LSB-byte-first into UART bytes, handshaking on `tx_busy` rising and falling rather than on fixed delays. It pulses `done` at frame end and can append a checksum byte.

## Interface
- `FRAME_LEN`, 3969: words per frame; range 1 to 2^`ADDR_W`.
- `DATA_W`, 8: memory word width; a multiple of 8, range 8–32.
- `ADDR_W`, 12: memory address width.
- `RD_LAT`, 2: memory read latency in clocks; range 1–3.
- `ACK_TO`, 4: clocks to wait for `tx_busy` to rise after a pulse before the byte counts as accepted.

- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  begins a frame when sampled high in IDLE; ignored otherwise.
- `busy`  out  1  high from the edge after `start` is accepted until FIN exits.
- `done`  out  1  one-cycle pulse in FIN.
- `rd_addr`  out  `ADDR_W`  memory read address.
- `rd_data`  in  `DATA_W`  memory read data, valid `RD_LAT` clocks after `rd_addr`.
- `tx_enable`  out  1  one-cycle byte-launch pulse to `uart_tx`.
- `tx_data`  out  8  byte to transmit; held stable from pulse until next SEND.
- `tx_busy`  in  1  UART transmitter busy.
- `words_sent`  out  `ADDR_W`+1  count of fully transmitted words in the current or last frame.

## Operation
- Reset values:
  - state IDLE.
  - `busy`=0, `done`=0, `tx_enable`=0.
  - `tx_data`=0, `rd_addr`=0, `words_sent`=0.
  - All internal counters and the checksum cleared.
- Reset mid-frame aborts immediately; no partial-byte completion and no `done`.
- States:
  - **IDLE:** on `start`, set `rd_addr`=0, `words_sent`=0, checksum=0; go to READ.
  - **READ:** latency counter runs for `RD_LAT` clocks, then go to LOAD.
  - **LOAD:** capture `rd_data` into the shift register; byte index=0; go to SEND.
  - **SEND:** if `tx_busy`=0, drive `tx_data`=shift[7:0], set `tx_enable`=1, add the byte to the checksum, and go to ACK. Otherwise stay in SEND.
  - **ACK:** `tx_enable`=0. Go to DRAIN when `tx_busy`=1, or when `ACK_TO` clocks elapse without it.
  - **DRAIN:** wait for `tx_busy`=0, then:
    - Bytes remain in the word: shift right 8 and go to SEND.
    - Word finished, not the last: increment `words_sent` and `rd_addr`, go to READ.
    - Last word: increment `words_sent`, then go to CSUM if enabled, else FIN.
  - **CSUM:** send the checksum byte through the same SEND/ACK/DRAIN handshake, flagged as the checksum byte; the checksum is not itself accumulated. Then go to FIN.
  - **FIN:** `done`=1 for one cycle, `busy` falls, go to IDLE. A `start` in FIN is ignored.
- Arithmetic:
  - Checksum is an 8-bit sum modulo 256.
  - `rd_addr` never exceeds `FRAME_LEN`-1 and does not wrap within a frame.
  - Byte index width is clog2(`DATA_W`/8), minimum 1.
- `tx_data` is registered; `tx_enable` is never high for two consecutive cycles.

## Timing
- `start` sampled at edge E0: `busy`=1 and `rd_addr`=0 after E0.
- First `tx_enable` is high in the cycle after edge E(`RD_LAT`+2), provided `tx_busy`=0.
- Per-byte overhead beyond UART time: 3 clocks (SEND, ACK, DRAIN exit).
- Per-word overhead beyond that: `RD_LAT`+1 clocks (READ, LOAD).
- `done` asserts the clock after the final DRAIN sees `tx_busy`=0; `busy` falls on the same edge that drops `done`.
- `tx_busy` stuck low: ACK advances after exactly `ACK_TO` clocks.
- `tx_busy` stuck high: DRAIN and SEND wait indefinitely; only `reset` exits.

## Configuration
- `RESULT_STREAM_CSUM_EN` defined: the checksum accumulator and CSUM state are compiled in, and the frame is `FRAME_LEN`*`DATA_W`/8+1 bytes.
- Undefined: no checksum logic; DRAIN goes directly to FIN; the frame is `FRAME_LEN`*`DATA_W`/8 bytes.

## Test plan
- `FRAME_LEN`=4, `DATA_W`=8, `RD_LAT`=2; memory holds 0x11,0x22,0x33,0x44; UART model busy 10 clocks per byte.
  - Bytes 11 22 33 44 in order, then `done` 1 cycle, `words_sent`=4.
  - With `RESULT_STREAM_CSUM_EN`, a fifth byte 0xAA.
- `DATA_W`=32, `FRAME_LEN`=2; words 0xA1B2C3D4, 0x01020304.
  - Bytes D4 C3 B2 A1 04 03 02 01; `rd_addr` sequence 0,1.
- `RD_LAT`=3; `start` at E0 with `tx_busy`=0.
  - First `tx_enable` high after E5; `start` re-pulsed while busy is ignored, giving exactly one frame.
- UART model that never raises `tx_busy`, `ACK_TO`=4.
  - Each byte advances 4 clocks after its pulse; the frame completes.
- `reset` asserted for 1 clock during the second byte of a 4-word frame.
  - All outputs return to their reset values next edge; no `done`; a new `start` resends from address 0.
